// File: rtl/seq_shift_right_unit.sv
// ---------------------------------------------------------------------------
// seq_shift_right_unit
//
// Multi-cycle right shifter for the execute stage. It handles SRL, SRLV, SRA
// and SRAV by moving the operand one bit position per clock. This trades
// latency for area compared with a full barrel shifter.
//
// Operation sequence:
//   IDLE  : waits for start. On an accepted start it latches the operand,
//           the shift amount and the fill bit.
//   SHIFT : shifts right by one bit per clock until the count is used up.
//   DONE  : pulses done for one cycle, then returns to IDLE.
//
// A shift amount of k gives a start-to-done latency of k+1 cycles.
// Because DONE always lasts one cycle, a new operation can be accepted
// every k+2 cycles.
//
// Ports:
//   clk      in   1        single clock, rising edge
//   rst      in   1        synchronous, active-high reset
//   start    in   1        request; only looked at in IDLE
//   data_in  in   WIDTH    operand, latched on the accepted start
//   shamt    in   SHAMT_W  shift amount, latched on the accepted start
//   arith    in   1        1 = arithmetic (sign fill), 0 = logical (zero fill)
//   busy     out  1        high in SHIFT and DONE
//   done     out  1        one-cycle pulse; result is valid in that cycle
//   result   out  WIDTH    shifted value; holds until the next accepted start
//
// Parameters:
//   WIDTH    data width in bits
//   SHAMT_W  shift-amount width; 2**SHAMT_W must cover WIDTH-1
// ---------------------------------------------------------------------------
module seq_shift_right_unit #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               arith,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t             state;
  logic [SHAMT_W-1:0] count;  // shifts still to perform
  logic               fill;   // bit shifted in at the MSB, fixed for the whole op

  // NOTE: every register in this block uses non-blocking assignments. All
  // right-hand sides therefore read pre-edge values. This matters most in
  // SHIFT, where the count==1 test must see the value before the decrement.
  always_ff @(posedge clk) begin
    if (rst) begin
      // Reset wins over everything. An operation in flight is dropped
      // without a done pulse.
      state  <= ST_IDLE;
      result <= '0;
      count  <= '0;
      fill   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            result <= data_in;
            count  <= shamt;
            // The sign is captured once from the original operand.
            // Later shifts never re-sample it.
            fill   <= arith & data_in[WIDTH-1];
            state  <= (shamt == '0) ? ST_DONE : ST_SHIFT;
          end
        end

        ST_SHIFT: begin
          result <= {fill, result[WIDTH-1:1]};
          count  <= count - SHAMT_W'(1);
          if (count == SHAMT_W'(1)) begin
            state <= ST_DONE;
          end
        end

        ST_DONE: begin
          // Leave DONE unconditionally. Start is not looked at here, so the
          // done cycle can never overlap a new acceptance.
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Moore outputs taken straight from the state register.
  // Because done is only high in ST_DONE, done implies busy.
  assign busy = (state == ST_SHIFT) || (state == ST_DONE);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_seq_shift_right_unit.sv
// ---------------------------------------------------------------------------
// tb_seq_shift_right_unit
//
// Directed self-checking bench for seq_shift_right_unit.
// Inputs change #1 after a rising edge. Outputs are sampled at the same
// point, so they are always read well away from the active edge.
// ---------------------------------------------------------------------------
module tb_seq_shift_right_unit;

  localparam int WIDTH   = 32;
  localparam int SHAMT_W = 5;

  logic               clk;
  logic               rst;
  logic               start;
  logic [WIDTH-1:0]   data_in;
  logic [SHAMT_W-1:0] shamt;
  logic               arith;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   result;

  int checks;
  int failures;

  seq_shift_right_unit #(
    .WIDTH   (WIDTH),
    .SHAMT_W (SHAMT_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .data_in (data_in),
    .shamt   (shamt),
    .arith   (arith),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge. Outputs are then stable and inputs may change.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Independent reference: the language's own shift operators.
  function automatic logic [WIDTH-1:0] ref_shift(input logic [WIDTH-1:0] d,
                                                 input int k,
                                                 input logic a);
    logic signed [WIDTH-1:0] sd;
    sd = d;
    if (a) return sd >>> k;
    else   return d >> k;
  endfunction

  // Start one operation. Then, for every cycle up to and including the done
  // cycle, check busy and done. In the done cycle, check result as well.
  // Finally check the first IDLE cycle after the operation.
  task automatic run_op(input string name, input logic [WIDTH-1:0] d,
                        input int k, input logic a,
                        input logic [WIDTH-1:0] exp);
    start = 1'b1; data_in = d; shamt = SHAMT_W'(k); arith = a;
    step();   // accepting edge N
    start = 1'b0;
    for (int i = 0; i <= k; i++) begin
      checks++;
      if (busy !== 1'b1 || done !== (i == k)) begin
        failures++;
        $display("FAIL %s cyc%0d busy/done got=%b%b exp=1%b", name, i, busy, done, (i == k));
      end
      if (i == k) begin
        checks++;
        if (result !== exp) begin
          failures++;
          $display("FAIL %s result got=%h exp=%h", name, result, exp);
        end
      end
      step();
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== exp) begin
      failures++;
      $display("FAIL %s after busy=%b done=%b result=%h exp 0 0 %h", name, busy, done, result, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; data_in = '0; shamt = '0; arith = 1'b0;
    step();
    step();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
      failures++;
      $display("FAIL reset busy=%b done=%b result=%h exp 0 0 00000000", busy, done, result);
    end
    rst = 1'b0;
    step();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
      failures++;
      $display("FAIL reset_idle busy=%b done=%b result=%h exp 0 0 00000000", busy, done, result);
    end
  endtask

  task automatic test_srl();
    run_op("srl4", 32'hF000_000F, 4, 1'b0, 32'h0F00_0000);
    run_op("srl1_neg", 32'h8000_0001, 1, 1'b0, 32'h4000_0000);
  endtask

  task automatic test_sra();
    run_op("sra31", 32'h8000_0000, 31, 1'b1, 32'hFFFF_FFFF);
    run_op("sra8_pos", 32'h7F00_0000, 8, 1'b1, 32'h007F_0000);
    run_op("sra5_neg", 32'hF000_0F00, 5, 1'b1, 32'hFF80_0078);
  endtask

  task automatic test_zero_shift();
    run_op("shamt0", 32'h1234_5678, 0, 1'b0, 32'h1234_5678);
    run_op("shamt0_arith", 32'h8765_4321, 0, 1'b1, 32'h8765_4321);
  endtask

  // Pulse start with a different operand while the unit is busy, including
  // during the DONE cycle. The original result must survive, and there must
  // be exactly one done pulse.
  task automatic test_busy_ignore();
    int k;
    int dones;
    k = 6;
    dones = 0;
    start = 1'b1; data_in = 32'hA5A5_0000; shamt = SHAMT_W'(k); arith = 1'b0;
    step();
    start = 1'b0;
    for (int i = 0; i <= k; i++) begin
      if (done === 1'b1) dones++;
      if (i >= 1) begin
        start = 1'b1; data_in = 32'hDEAD_BEEF; shamt = 5'd1; arith = 1'b1;
      end
      step();
    end
    // Now in IDLE, after the DONE edge. Drop start before it can be taken.
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (done === 1'b1) dones++;
      step();
    end
    checks++;
    if (dones != 1) begin
      failures++;
      $display("FAIL busy_ignore done_count got=%0d exp=1", dones);
    end
    checks++;
    if (result !== 32'h02969400 || busy !== 1'b0) begin
      failures++;
      $display("FAIL busy_ignore result got=%h busy=%b exp=02969400 busy=0", result, busy);
    end
  endtask

  // Assert reset at the edge that would perform the 3rd shift of shamt=10.
  task automatic test_reset_mid();
    int dones;
    dones = 0;
    start = 1'b1; data_in = 32'hFFFF_0000; shamt = 5'd10; arith = 1'b1;
    step();   // edge N
    start = 1'b0;
    step();   // edge N+1, shift 1
    step();   // edge N+2, shift 2
    rst = 1'b1;
    step();   // edge N+3, reset instead of shift 3
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
      failures++;
      $display("FAIL reset_mid busy=%b done=%b result=%h exp 0 0 00000000", busy, done, result);
    end
    rst = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (done === 1'b1 || busy !== 1'b0 || result !== 32'h0) dones++;
    end
    checks++;
    if (dones != 0) begin
      failures++;
      $display("FAIL reset_mid_after bad_cycles got=%0d exp=0", dones);
    end
  endtask

  // Hold start high throughout. Each operation takes k+2 cycles, from
  // acceptance to the next acceptance.
  task automatic test_back_to_back();
    logic [WIDTH-1:0] vd [5];
    int               vk [5];
    logic             va [5];
    logic [WIDTH-1:0] exp;
    vd[0] = 32'h8000_00F0; vk[0] = 3;  va[0] = 1'b1;
    vd[1] = 32'h8000_00F0; vk[1] = 3;  va[1] = 1'b0;
    vd[2] = 32'hCAFE_F00D; vk[2] = 0;  va[2] = 1'b1;
    vd[3] = 32'h9ABC_DEF0; vk[3] = 12; va[3] = 1'b1;
    vd[4] = 32'h0123_4567; vk[4] = 7;  va[4] = 1'b1;
    start = 1'b1; data_in = vd[0]; shamt = SHAMT_W'(vk[0]); arith = va[0];
    step();   // first acceptance
    for (int j = 0; j < 5; j++) begin
      exp = ref_shift(vd[j], vk[j], va[j]);
      for (int i = 0; i <= vk[j] + 1; i++) begin
        checks++;
        if (busy !== (i <= vk[j]) || done !== (i == vk[j])) begin
          failures++;
          $display("FAIL b2b op%0d cyc%0d busy/done got=%b%b exp=%b%b",
                   j, i, busy, done, (i <= vk[j]), (i == vk[j]));
        end
        if (i == vk[j]) begin
          checks++;
          if (result !== exp) begin
            failures++;
            $display("FAIL b2b op%0d result got=%h exp=%h", j, result, exp);
          end
        end
        if (i == vk[j] + 1) begin
          if (j < 4) begin
            data_in = vd[j+1]; shamt = SHAMT_W'(vk[j+1]); arith = va[j+1];
          end else begin
            start = 1'b0;
          end
        end
        step();
      end
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL b2b_end busy=%b done=%b exp 0 0", busy, done);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_srl();
    test_sra();
    test_zero_shift();
    test_busy_ignore();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
